gate2_bist: RTL and testbench

Hardware self-test sequencer for a single 2-input logic gate: it drives the gate's inputs through all four input vectors, holds each one for a programmable settle time, samples the gate output and compares it against an expected truth table. The block sits opposite the gate under test, driving its `a` and `b` inputs and observing its `c` output. It reports a per-vector fail mask, a fail count and a pass/done status to the surrounding control logic.

---
 rtl/gate2_bist.sv | 116 +++++++++++
 tb/tb_gate2_bist.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/gate2_bist.sv
// Self-test sequencer for one 2-input gate: steps {a,b} through 00..11, waits
// SETTLE cycles per vector, samples c and checks it against the TRUTH table.
module gate2_bist #(
    parameter logic [3:0] TRUTH  = 4'b1000,
    parameter int         SETTLE = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] fail_count
);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FINISH} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [1:0]  vec_q, vec_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        a_q, a_d;
    logic        b_q, b_d;
    logic [3:0]  mask_q, mask_d;
    logic [2:0]  count_q, count_d;
    logic        pass_q, pass_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= 8'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            mask_q  <= 4'd0;
            count_q <= 3'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        mask_d  = mask_q;
        count_d = count_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = 4'd0;
                    count_d = 3'd0;
                    pass_d  = 1'b0;
                    vec_d   = 2'd0;
                    cnt_d   = 8'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (c != TRUTH[vec_q]) begin
                    mask_d[vec_q] = 1'b1;
                    count_d       = count_q + 3'd1;
                end
                if (vec_q == 2'd3) begin
                    state_d = FINISH;
                end else begin
                    // Drive the next vector at the same edge the sample is taken.
                    vec_d      = vec_q + 2'd1;
                    cnt_d      = 8'd0;
                    {a_d, b_d} = vec_q + 2'd1;
                    state_d    = APPLY;
                end
            end
            FINISH: begin
                pass_d  = (mask_q == 4'd0);
                a_d     = 1'b0;
                b_d     = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign a          = a_q;
    assign b          = b_q;
    assign busy       = (state_q == APPLY) || (state_q == SAMPLE);
    assign done       = (state_q == FINISH);
    assign pass       = pass_q;
    assign fail_mask  = mask_q;
    assign fail_count = count_q;

endmodule

// File: tb/tb_gate2_bist.sv
// Bench for gate2_bist: two instances (AND table / SETTLE=10, OR table / SETTLE=1)
// driving a gate modelled as a 4-entry truth table, checked cycle by cycle.
module tb_gate2_bist;

    localparam logic [3:0] TRUTH_A = 4'b1000;
    localparam logic [3:0] TRUTH_B = 4'b1110;
    localparam int         SET_A   = 10;
    localparam int         SET_B   = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start_s;
    logic [1:0] a_s, b_s, c_s, busy_s, done_s, pass_s;
    logic [3:0] mask_s [2];
    logic [2:0] cnt_s  [2];
    logic [3:0] tt_s   [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign c_s[0] = tt_s[0][{a_s[0], b_s[0]}];
    assign c_s[1] = tt_s[1][{a_s[1], b_s[1]}];

    gate2_bist #(.TRUTH(TRUTH_A), .SETTLE(SET_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_s[0]),
        .a(a_s[0]), .b(b_s[0]), .c(c_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .fail_mask(mask_s[0]), .fail_count(cnt_s[0])
    );

    gate2_bist #(.TRUTH(TRUTH_B), .SETTLE(SET_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_s[1]),
        .a(a_s[1]), .b(b_s[1]), .c(c_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .fail_mask(mask_s[1]), .fail_count(cnt_s[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One run on instance sel. Entry: #1 after an edge with that instance idle.
    // noise: random start toggles while the run is in progress.
    // hold: leave start high after the run so the next run follows back-to-back.
    task automatic run(input int sel, input logic [3:0] tt, input bit noise, input bit hold);
        int         s;
        int         len;
        logic [3:0] exp_mask;
        logic [1:0] v;
        s        = (sel == 0) ? SET_A : SET_B;
        len      = 4 * (s + 1);
        exp_mask = tt ^ ((sel == 0) ? TRUTH_A : TRUTH_B);
        tt_s[sel]    = tt;
        start_s[sel] = 1'b1;
        tick();
        for (int k = 0; k <= len + 1; k++) begin
            if (k == 0)
                chk("cleared_at_start", {8'd0, pass_s[sel], mask_s[sel], cnt_s[sel]}, 16'd0);
            if (k < len) begin
                v = 2'(k / (s + 1));
                chk("run_busy_vec", {12'd0, busy_s[sel], done_s[sel], a_s[sel], b_s[sel]},
                    {12'd0, 1'b1, 1'b0, v[1], v[0]});
            end else if (k == len) begin
                chk("finish_done", {13'd0, busy_s[sel], done_s[sel], pass_s[sel]}, 16'b010);
            end else begin
                chk("idle_after", {12'd0, busy_s[sel], done_s[sel], a_s[sel], b_s[sel]}, 16'd0);
                chk("fail_mask", {12'd0, mask_s[sel]}, {12'd0, exp_mask});
                chk("fail_count", {13'd0, cnt_s[sel]}, 16'($countones(exp_mask)));
                chk("pass", {15'd0, pass_s[sel]}, {15'd0, exp_mask == 4'd0});
            end
            if (k <= len) begin
                start_s[sel] = hold ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
                tick();
            end else begin
                start_s[sel] = hold;
            end
        end
        $display("run inst=%0d tt=%b mask=%b count=%0d pass=%0d",
                 sel, tt, mask_s[sel], cnt_s[sel], pass_s[sel]);
    endtask

    initial begin
        rst      = 1'b1;
        start_s  = 2'b00;
        tt_s[0]  = 4'd0;
        tt_s[1]  = 4'd0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++)
            chk("reset_values", {3'd0, a_s[i], b_s[i], busy_s[i], done_s[i], pass_s[i],
                                 mask_s[i], cnt_s[i]}, 16'd0);
        rst = 1'b0;
        tick();

        // Directed gate models on the AND-table instance.
        run(0, 4'b1000, 0, 0);   // correct AND
        tick();
        run(0, 4'b0000, 0, 0);   // stuck at 0
        tick();
        run(0, 4'b1111, 0, 0);   // stuck at 1
        tick();
        // OR-table instance with the shortest settle time.
        run(1, 4'b1110, 0, 0);   // OR gate: pass
        tick();
        run(1, 4'b1000, 0, 0);   // AND gate: mask 0110
        tick();
        // Random gates with start noise during the run.
        for (int i = 0; i < 4; i++) begin
            run(0, 4'($urandom_range(0, 15)), 1, 0);
            tick();
            run(1, 4'($urandom_range(0, 15)), 1, 0);
            tick();
        end
        // start held high: back-to-back runs, results cleared at each restart.
        run(0, 4'b1111, 0, 1);
        run(0, 4'b1000, 0, 1);
        run(0, 4'($urandom_range(0, 15)), 0, 0);
        tick();

        // Reset during APPLY of vector 2.
        tt_s[0]    = 4'b0000;
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        repeat (25) tick();
        chk("mid_run_vec2", {14'd0, a_s[0], b_s[0]}, 16'b10);
        rst = 1'b1;
        tick();
        chk("abort_reset_values", {3'd0, a_s[0], b_s[0], busy_s[0], done_s[0], pass_s[0],
                                   mask_s[0], cnt_s[0]}, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            chk("no_done_after_abort", {14'd0, busy_s[0], done_s[0]}, 16'd0);
            tick();
        end
        run(0, 4'b1000, 0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
